// File: rtl/popcount_select_pkg.sv
// Shared math-library definitions for popcount_select: state encoding and
// the width derivations used by the rank/index ports.
package popcount_select_pkg;

    // FSM state encoding, kept as plain constants for legacy compatibility.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-index width for a vector of in_size bits.
    function automatic int levels_of(input int in_size);
        return $clog2(in_size);
    endfunction

    // Rank width: one more bit than the index so that rank == in_size fits.
    function automatic int rank_width(input int in_size);
        return $clog2(in_size) + 1;
    endfunction

endpackage

// File: rtl/chunk_select.sv
// Combinational per-chunk helper: popcount of one slice, whether the
// requested rank lands inside it, and the offset of that set bit.
module chunk_select #(
    parameter int CHUNK  = 8,
    parameter int RANK_W = 7,
    parameter int CNT_W  = $clog2(CHUNK) + 1,
    parameter int OFF_W  = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0]  chunk,
    input  logic [RANK_W-1:0] rank_in,
    output logic [CNT_W-1:0]  count,
    output logic              hit,
    output logic [OFF_W-1:0]  offset
);

    logic seen;

    // Ripple through the slice counting ones and latching the position of
    // the rank_in-th one the first time the running count reaches it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        count  = '0;
        offset = '0;
        seen   = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) begin
                count = count + CNT_W'(1);
                if (!seen && (RANK_W'(count) == rank_in)) begin
                    offset = OFF_W'(i);
                    seen   = 1'b1;
                end
            end
        end
    end

    // A zero rank never hits; otherwise hit when the slice holds enough ones.
    assign hit = (rank_in != '0) && (RANK_W'(count) >= rank_in);

endmodule

// File: rtl/popcount_select.sv
// Sequential rank-to-position unit: returns the index of the k-th set bit
// (k from 1, counted from the LSB), scanning one CHUNK-bit slice per cycle.
module popcount_select
    import popcount_select_pkg::*;
#(
    parameter int IN_SIZE  = 64,
    parameter int CHUNK    = 8,
    parameter int LEVELS   = levels_of(IN_SIZE),
    parameter int OUT_SIZE = rank_width(IN_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in_bits,
    input  logic [OUT_SIZE-1:0] in_rank,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEVELS-1:0]   out_index,
    output logic                out_found
);

    localparam int CLOG_CHUNK = $clog2(CHUNK);
    localparam int N_CHUNKS   = IN_SIZE / CHUNK;
    localparam int PTR_W      = (LEVELS > CLOG_CHUNK) ? LEVELS - CLOG_CHUNK : 1;
    localparam int CNT_W      = CLOG_CHUNK + 1;
    localparam int OFF_W      = (CLOG_CHUNK > 0) ? CLOG_CHUNK : 1;

    logic [1:0]          state;
    logic [IN_SIZE-1:0]  bits_q;
    logic [OUT_SIZE-1:0] rank_q;
    logic [PTR_W-1:0]    ptr;

    logic [LEVELS-1:0]   base;
    logic [CHUNK-1:0]    cur_chunk;
    logic [CNT_W-1:0]    chunk_cnt;
    logic                chunk_hit;
    logic [OFF_W-1:0]    chunk_off;
    logic                rank_bad;
    logic                last_chunk;

    // Handshake flags decode straight from state: no out_ready -> in_ready path.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Slice currently under examination and scan bookkeeping.
    assign base       = LEVELS'(ptr) << CLOG_CHUNK;
    assign cur_chunk  = bits_q[base +: CHUNK];
    assign last_chunk = (ptr == PTR_W'(N_CHUNKS - 1));
    // Out-of-range ranks are rejected on the first scan cycle so every
    // result, good or bad, appears at least one edge after acceptance.
    assign rank_bad   = (rank_q == '0) || (rank_q > OUT_SIZE'(IN_SIZE));

    chunk_select #(
        .CHUNK  (CHUNK),
        .RANK_W (OUT_SIZE),
        .CNT_W  (CNT_W),
        .OFF_W  (OFF_W)
    ) u_chunk_select (
        .chunk   (cur_chunk),
        .rank_in (rank_q),
        .count   (chunk_cnt),
        .hit     (chunk_hit),
        .offset  (chunk_off)
    );

    // FSM, operand capture, residual-rank walk and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand register is reset along with control state;
            // it is only one vector wide, so a deterministic power-up value
            // costs nothing worth saving.
            state     <= ST_IDLE;
            bits_q    <= '0;
            rank_q    <= '0;
            ptr       <= '0;
            out_index <= '0;
            out_found <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge values of state, rank_q and ptr.
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bits_q <= in_bits;
                        rank_q <= in_rank;
                        ptr    <= '0;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (rank_bad) begin
                        out_index <= '0;
                        out_found <= 1'b0;
                        state     <= ST_DONE;
                    end else if (chunk_hit) begin
                        out_index <= base + LEVELS'(chunk_off);
                        out_found <= 1'b1;
                        state     <= ST_DONE;
                    end else if (last_chunk) begin
                        out_index <= '0;
                        out_found <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        // Only reached when rank_q > chunk_cnt: no underflow.
                        rank_q <= rank_q - OUT_SIZE'(chunk_cnt);
                        ptr    <= ptr + PTR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_select.sv
// Directed self-checking bench for popcount_select at default parameters.
module tb_popcount_select;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits;
    logic [6:0]  in_rank;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic        out_found;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_select #(
        .IN_SIZE (64),
        .CHUNK   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_found (out_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Offer one request, count edges to out_valid, check the result and,
    // when out_ready is high, the handshake back to IDLE.
    task automatic run(input string tag, input logic [63:0] bits, input logic [6:0] k,
                       input logic [5:0] exp_idx, input logic exp_found, input int exp_edge);
        int e;
        @(negedge clk);
        check({tag, ".ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_bits  = bits;
        in_rank  = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bits  = '1;
        in_rank  = '0;
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
        e = 0;
        while (e < 20) begin
            @(posedge clk);
            e++;
            #1;
            if (out_valid) break;
        end
        check({tag, ".edge"}, 64'(e), 64'(exp_edge));
        check({tag, ".index"}, 64'(out_index), 64'(exp_idx));
        check({tag, ".found"}, 64'(out_found), 64'(exp_found));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, ".ready_after"}, 64'(in_ready), 64'd1);
            check({tag, ".valid_after"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bits   = '0;
        in_rank   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_index", 64'(out_index), 64'd0);
        check("rst.out_found", 64'(out_found), 64'd0);

        run("lsb",     64'h1,                  7'd1,  6'd0,  1'b1, 1);
        run("msb",     64'h8000_0000_0000_0000, 7'd1,  6'd63, 1'b1, 8);
        run("nib13",   64'h0F0F_0F0F_0F0F_0F0F, 7'd13, 6'd24, 1'b1, 4);
        run("nib33",   64'h0F0F_0F0F_0F0F_0F0F, 7'd33, 6'd0,  1'b0, 8);
        run("ones64",  64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 6'd63, 1'b1, 8);
        run("ones0",   64'hFFFF_FFFF_FFFF_FFFF, 7'd0,  6'd0,  1'b0, 1);
        run("ones65",  64'hFFFF_FFFF_FFFF_FFFF, 7'd65, 6'd0,  1'b0, 1);
        run("mid",     64'h0000_0000_00A0_0000, 7'd2,  6'd23, 1'b1, 3);

        // Backpressure: result held in DONE while a competing request waits.
        out_ready = 1'b0;
        run("bp", 64'h10, 7'd1, 6'd4, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bits  = 64'h1;
            in_rank  = 7'd1;
            @(posedge clk);
            #1;
            check("bp.valid", 64'(out_valid), 64'd1);
            check("bp.index", 64'(out_index), 64'd4);
            check("bp.found", 64'(out_found), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release_ready", 64'(in_ready), 64'd1);
        check("bp.release_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a scan that would otherwise run to the end.
        @(negedge clk);
        in_valid = 1'b1;
        in_bits  = 64'h0;
        in_rank  = 7'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.in_ready", 64'(in_ready), 64'd1);
        check("arst.out_found", 64'(out_found), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 64'h100, 7'd1, 6'd8, 1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
